// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver: latches a coherent frame of
// display codes, decodes each digit and scans them onto two 4-digit segment buses.
module seg_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] disp_code,
  input  logic [7:0]  dp_mask,
  input  logic        blank,
  output logic [7:0]  choose,
  output logic [7:0]  seg_left,
  output logic [7:0]  seg_right,
  output logic        frame_start
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [47:0] BLANK_FRAME = {8{6'd63}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [2:0]       idx, idx_nxt;
  logic [47:0]      shadow, shadow_nxt;
  logic [7:0]       dp_sh, dp_nxt;
  logic             latch;
  logic [5:0]       code_sel;
  logic [7:0]       seg_pat;

  // Segment pattern {a,b,c,d,e,f,g}; unused codes are dark.
  function automatic logic [6:0] decode(input logic [5:0] code);
    case (code)
      6'd0:    decode = 7'b1111110;
      6'd1:    decode = 7'b0110000;
      6'd2:    decode = 7'b1101101;
      6'd3:    decode = 7'b1111001;
      6'd4:    decode = 7'b0110011;
      6'd5:    decode = 7'b1011011;
      6'd6:    decode = 7'b1011111;
      6'd7:    decode = 7'b1110000;
      6'd8:    decode = 7'b1111111;
      6'd9:    decode = 7'b1111011;
      6'd10:   decode = 7'b1110111;
      6'd11:   decode = 7'b0011111;
      6'd12:   decode = 7'b1001110;
      6'd13:   decode = 7'b0111101;
      6'd14:   decode = 7'b1001111;
      6'd15:   decode = 7'b1000111;
      6'd16:   decode = 7'b0110111;
      6'd17:   decode = 7'b0001110;
      6'd18:   decode = 7'b1100111;
      6'd19:   decode = 7'b0000101;
      6'd20:   decode = 7'b1011011;
      6'd21:   decode = 7'b0111110;
      6'd22:   decode = 7'b0000001;
      default: decode = 7'b0000000;
    endcase
  endfunction

  assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          latch     = 1'b1;
          idx_nxt   = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (tick) begin
          if (idx == 3'd7) begin
            latch   = 1'b1;
            idx_nxt = '0;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are built from post-tick index/shadow so the new digit lands one cycle after tick.
  assign shadow_nxt = latch ? disp_code : shadow;
  assign dp_nxt     = latch ? dp_mask   : dp_sh;
  assign code_sel   = shadow_nxt[int'(idx_nxt) * 6 +: 6];
  assign seg_pat    = {decode(code_sel), dp_nxt[idx_nxt]};

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= BLANK_FRAME;
      dp_sh       <= '0;
      frame_start <= 1'b0;
    end else begin
      shadow      <= shadow_nxt;
      dp_sh       <= dp_nxt;
      frame_start <= latch;
    end
  end

  // blank clears immediately but only a tick repaints, so resumption is slot-aligned.
  always_ff @(posedge clk) begin
    if (rst || blank) begin
      choose    <= '0;
      seg_left  <= '0;
      seg_right <= '0;
    end else if (tick) begin
      choose    <= 8'(1) << idx_nxt;
      seg_left  <= idx_nxt[2] ? seg_pat : 8'h00;
      seg_right <= idx_nxt[2] ? 8'h00 : seg_pat;
    end
  end

endmodule
